// File: rtl/wb_depp_simple_pkg.sv
// Shared definitions for the EPP-to-Wishbone bridge: register indices,
// FSM states, status bit positions and byte-lane helpers.
package wb_depp_simple_pkg;

    localparam logic [7:0] IDX_ADDR0  = 8'd0;
    localparam logic [7:0] IDX_ADDR1  = 8'd1;
    localparam logic [7:0] IDX_ADDR2  = 8'd2;
    localparam logic [7:0] IDX_ADDR3  = 8'd3;
    localparam logic [7:0] IDX_DATA0  = 8'd4;
    localparam logic [7:0] IDX_DATA1  = 8'd5;
    localparam logic [7:0] IDX_DATA2  = 8'd6;
    localparam logic [7:0] IDX_DATA3  = 8'd7;
    localparam logic [7:0] IDX_STATUS = 8'd8;

    localparam int unsigned STAT_INT  = 32'd0;
    localparam int unsigned STAT_ERR  = 32'd1;
    localparam int unsigned STAT_BUSY = 32'd2;

    typedef enum logic [1:0] {IDLE, XFER, BUS, HOLD} state_t;

    // Byte lanes are big-endian: lane 0 is bits 31:24.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        case (sel)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] w, input logic [1:0] sel,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (sel)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_depp_simple_if.sv
// EPP host pins plus Wishbone master bus of the bridge; the master modport
// is the bridge view, the slave modport is the host/interconnect view.
interface wb_depp_simple_if;
    logic        i_astb_n;
    logic        i_dstb_n;
    logic        i_write_n;
    logic [7:0]  i_depp;
    logic [7:0]  o_depp;
    logic        o_wait;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic        i_wb_err;
    logic [31:0] i_wb_data;
    logic        i_int;

    modport master (
        input  i_astb_n, i_dstb_n, i_write_n, i_depp,
        input  i_wb_ack, i_wb_stall, i_wb_err, i_wb_data, i_int,
        output o_depp, o_wait,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );

    modport slave (
        output i_astb_n, i_dstb_n, i_write_n, i_depp,
        output i_wb_ack, i_wb_stall, i_wb_err, i_wb_data, i_int,
        input  o_depp, o_wait,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );
endinterface

// File: rtl/wb_depp_simple_depp_sync.sv
// Parameterized multi-stage synchronizer for asynchronous EPP inputs.
module depp_sync #(
    parameter int                 WIDTH   = 1,
    parameter int                 STAGES  = 2,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift chain; reset loads the inactive level so strobes read as released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage_r[i] <= RST_VAL;
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) stage_r[i] <= stage_r[i-1];
        end
    end

    assign q = stage_r[STAGES-1];
endmodule

// File: rtl/wb_depp_simple.sv
// EPP host port to 32-bit pipelined Wishbone master: byte-wide index/data
// registers on the host side, single read/write bus cycles on the system side.
module wb_depp_simple
    import wb_depp_simple_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    wb_depp_simple_if.master  bus
);
    logic [2:0]  ctl_s;
    logic [7:0]  depp_s;
    logic        astb_s, dstb_s, write_n_s;

    state_t      state_r, state_next;
    logic        wait_r, wait_next;
    logic [7:0]  index_r, depp_r, rd_byte_s, status_s;
    logic [31:0] addr_r, wdata_r, rdata_r;
    logic        cyc_r, stb_r, we_r, err_r;
    logic        addr_ev_s, data_ev_s, launch_s, launch_we_s, status_rd_s;

    depp_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RST_VAL(3'b111)) u_sync_ctl (
        .clk(i_clk), .rst_n(i_rst_n),
        .d({bus.i_astb_n, bus.i_dstb_n, bus.i_write_n}), .q(ctl_s)
    );

    depp_sync #(.WIDTH(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_data (
        .clk(i_clk), .rst_n(i_rst_n), .d(bus.i_depp), .q(depp_s)
    );

    assign astb_s    = ctl_s[2];
    assign dstb_s    = ctl_s[1];
    assign write_n_s = ctl_s[0];

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            wait_r  <= 1'b0;
        end else begin
            state_r <= state_next;
            wait_r  <= wait_next;
        end
    end

    // Next state, strobe events and launch decode; astb wins over dstb.
    always_comb begin
        state_next  = state_r;
        wait_next   = wait_r;
        addr_ev_s   = 1'b0;
        data_ev_s   = 1'b0;
        launch_s    = 1'b0;
        launch_we_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!astb_s && !wait_r) begin
                    addr_ev_s  = 1'b1;
                    state_next = XFER;
                    wait_next  = 1'b1;
                end else if (!dstb_s && !wait_r) begin
                    data_ev_s  = 1'b1;
                    state_next = XFER;
                    if (!write_n_s && (index_r == IDX_ADDR3 || index_r == IDX_DATA3)) begin
                        launch_s    = 1'b1;
                        launch_we_s = (index_r == IDX_DATA3);
                        wait_next   = 1'b0;
                    end else begin
                        wait_next   = 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            XFER: begin
                if (cyc_r) begin
                    state_next = BUS;
                end else begin
                    state_next = HOLD;
                end
            end
            BUS: begin
                if (!cyc_r) begin
                    state_next = HOLD;
                    wait_next  = 1'b1;
                end else begin
                    state_next = BUS;
                end
            end
            HOLD: begin
                if (astb_s && dstb_s) begin
                    state_next = IDLE;
                    wait_next  = 1'b0;
                end else begin
                    state_next = HOLD;
                end
            end
            default: begin
                state_next = IDLE;
                wait_next  = 1'b0;
            end
        endcase
    end

    // Host read-back mux over the register index.
    always_comb begin
        status_s            = 8'h00;
        status_s[STAT_INT]  = bus.i_int;
        status_s[STAT_ERR]  = err_r;
        status_s[STAT_BUSY] = cyc_r;
        if (index_r <= IDX_ADDR3) begin
            rd_byte_s = word_byte(addr_r, index_r[1:0]);
        end else if (index_r <= IDX_DATA3) begin
            rd_byte_s = word_byte(rdata_r, index_r[1:0]);
        end else if (index_r == IDX_STATUS) begin
            rd_byte_s = status_s;
        end else begin
            rd_byte_s = 8'h00;
        end
    end

    assign status_rd_s = data_ev_s && write_n_s && (index_r == IDX_STATUS);

    // Host-visible registers, updated at the strobe event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            index_r <= 8'h00;
            depp_r  <= 8'h00;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if (addr_ev_s) begin
            if (!write_n_s) index_r <= depp_s;
            else            depp_r  <= index_r;
        end else if (data_ev_s) begin
            if (write_n_s) begin
                depp_r <= rd_byte_s;
            end else if (index_r <= IDX_ADDR3) begin
                addr_r <= set_byte(addr_r, index_r[1:0], depp_s);
            end else if (index_r <= IDX_DATA3) begin
                wdata_r <= set_byte(wdata_r, index_r[1:0], depp_s);
            end
        end
    end

    // Wishbone master: stb leaves on acceptance, cyc leaves on ack/err.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else begin
            if (launch_s) begin
                cyc_r <= 1'b1;
                stb_r <= 1'b1;
                we_r  <= launch_we_s;
            end else if (cyc_r) begin
                if (stb_r && !bus.i_wb_stall) stb_r <= 1'b0;
                if (bus.i_wb_ack || bus.i_wb_err) begin
                    cyc_r <= 1'b0;
                    stb_r <= 1'b0;
                end
                if (bus.i_wb_ack && !bus.i_wb_err && !we_r) rdata_r <= bus.i_wb_data;
            end
            if (cyc_r && bus.i_wb_err) err_r <= 1'b1;
            else if (status_rd_s)      err_r <= 1'b0;
        end
    end

    assign bus.o_depp    = depp_r;
    assign bus.o_wait    = wait_r;
    assign bus.o_wb_cyc  = cyc_r;
    assign bus.o_wb_stb  = stb_r;
    assign bus.o_wb_we   = we_r;
    assign bus.o_wb_addr = addr_r;
    assign bus.o_wb_data = wdata_r;
endmodule

// File: tb/tb_wb_depp_simple.sv
// Directed bench for wb_depp_simple: EPP host driver, Wishbone slave responder.
module tb_wb_depp_simple;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_depp_simple_if bus();
    wb_depp_simple #(.SYNC_STAGES(2)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Slave configuration (written by the main sequence) and observations.
    int          stall_cfg = 0;
    bit          use_err   = 1'b0;
    logic [31:0] rd_cfg    = 32'h0;
    int          stb_cnt   = 0;
    int          cyc_cnt   = 0;
    int          stall_left = 0;
    bit          seen = 1'b0, pending = 1'b0, wait_early = 1'b0;
    logic        last_we = 1'b0;
    logic [31:0] last_data = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wishbone slave: optional stall, then one-clock ack or err after acceptance.
    initial begin
        bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0; bus.i_wb_stall = 1'b0; bus.i_wb_data = 32'h0;
        forever begin
            @(negedge clk);
            bus.i_wb_ack = 1'b0;
            bus.i_wb_err = 1'b0;
            if (!bus.o_wb_cyc) begin
                seen = 1'b0; pending = 1'b0; bus.i_wb_stall = 1'b0;
            end else begin
                if (bus.o_wait) wait_early = 1'b1;
                if (!seen) begin
                    seen = 1'b1; stall_left = stall_cfg; stb_cnt = 0; cyc_cnt++;
                    last_we = bus.o_wb_we; last_data = bus.o_wb_data;
                end
                if (pending) begin
                    pending = 1'b0;
                    if (use_err) bus.i_wb_err = 1'b1;
                    else begin bus.i_wb_ack = 1'b1; bus.i_wb_data = rd_cfg; end
                end else if (bus.o_wb_stb) begin
                    stb_cnt++;
                    if (stall_left > 0) begin bus.i_wb_stall = 1'b1; stall_left--; end
                    else begin bus.i_wb_stall = 1'b0; pending = 1'b1; end
                end
            end
        end
    end

    // One EPP access; kind 0 = address strobe, 1 = data strobe, 2 = both.
    // rise/fall count clocks from strobe edge to o_wait change (200 = timeout).
    task automatic epp(input int kind, input bit wr, input logic [7:0] din,
                       output logic [7:0] dout, output int rise, output int fall);
        @(negedge clk);
        bus.i_write_n = !wr;
        bus.i_depp    = din;
        if (kind != 1) bus.i_astb_n = 1'b0;
        if (kind != 0) bus.i_dstb_n = 1'b0;
        rise = 0;
        while (rise < 200) begin
            @(posedge clk); #1; rise++;
            if (bus.o_wait) break;
        end
        dout = bus.o_depp;
        @(negedge clk);
        bus.i_astb_n = 1'b1;
        bus.i_dstb_n = 1'b1;
        fall = 0;
        while (fall < 200) begin
            @(posedge clk); #1; fall++;
            if (!bus.o_wait) break;
        end
        if (rise >= 200 || fall >= 200) chk("epp_handshake_timeout", 32'd1, 32'd0);
    endtask

    logic [7:0]  d;
    int          r, f;
    logic [7:0]  bytes [4];

    initial begin
        bus.i_astb_n = 1'b1; bus.i_dstb_n = 1'b1; bus.i_write_n = 1'b1;
        bus.i_depp = 8'h00; bus.i_int = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wait", {31'd0, bus.o_wait}, 32'd0);
        chk("rst_cyc",  {31'd0, bus.o_wb_cyc}, 32'd0);
        chk("rst_stb",  {31'd0, bus.o_wb_stb}, 32'd0);
        chk("rst_we",   {31'd0, bus.o_wb_we}, 32'd0);
        chk("rst_depp", {24'd0, bus.o_depp}, 32'd0);
        chk("rst_addr", bus.o_wb_addr, 32'd0);
        chk("rst_data", bus.o_wb_data, 32'd0);
        rst_n = 1'b1;

        // Index register write and read-back, handshake latency both ways.
        epp(0, 1'b1, 8'h05, d, r, f);
        chk("aw_rise", r, 32'd3);
        chk("aw_fall", f, 32'd3);
        epp(0, 1'b0, 8'h00, d, r, f);
        chk("ar_val", {24'd0, d}, 32'h05);
        chk("ar_rise", r, 32'd3);

        // Address load; index 3 launches a read returning CAFEF00D.
        rd_cfg = 32'hCAFE_F00D;
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
        for (int i = 0; i < 4; i++) begin
            epp(0, 1'b1, 8'(i), d, r, f);
            epp(1, 1'b1, bytes[i], d, r, f);
        end
        chk("rd_launch_rise", r, 32'd6);
        chk("addr_word", bus.o_wb_addr, 32'h1234_5678);
        chk("rd_cyc_cnt", cyc_cnt, 32'd1);
        chk("rd_we", {31'd0, last_we}, 32'd0);
        epp(0, 1'b1, 8'h00, d, r, f);
        epp(1, 1'b0, 8'h00, d, r, f);
        chk("addr0_rb", {24'd0, d}, 32'h12);
        bytes[0] = 8'hCA; bytes[1] = 8'hFE; bytes[2] = 8'hF0; bytes[3] = 8'h0D;
        for (int i = 0; i < 4; i++) begin
            epp(0, 1'b1, 8'(4 + i), d, r, f);
            epp(1, 1'b0, 8'h00, d, r, f);
            chk("rdata_byte", {24'd0, d}, {24'd0, bytes[i]});
        end

        // Write DEADBEEF with three stall clocks.
        stall_cfg = 3;
        bytes[0] = 8'hDE; bytes[1] = 8'hAD; bytes[2] = 8'hBE; bytes[3] = 8'hEF;
        for (int i = 0; i < 4; i++) begin
            epp(0, 1'b1, 8'(4 + i), d, r, f);
            epp(1, 1'b1, bytes[i], d, r, f);
        end
        chk("wr_launch_rise", r, 32'd9);
        chk("wr_cyc_cnt", cyc_cnt, 32'd2);
        chk("wr_we", {31'd0, last_we}, 32'd1);
        chk("wr_bus_data", last_data, 32'hDEAD_BEEF);
        chk("wr_stb_clks", stb_cnt, 32'd4);
        chk("wr_wait_low", {31'd0, wait_early}, 32'd0);
        epp(0, 1'b1, 8'h05, d, r, f);
        epp(1, 1'b0, 8'h00, d, r, f);
        chk("rdata_kept_after_wr", {24'd0, d}, 32'hFE);

        // Error response to a read.
        stall_cfg = 0; use_err = 1'b1; rd_cfg = 32'h1122_3344;
        epp(0, 1'b1, 8'h03, d, r, f);
        epp(1, 1'b1, 8'h78, d, r, f);
        chk("err_cyc_cnt", cyc_cnt, 32'd3);
        chk("err_cyc_low", {31'd0, bus.o_wb_cyc}, 32'd0);
        epp(0, 1'b1, 8'h08, d, r, f);
        epp(1, 1'b0, 8'h00, d, r, f);
        chk("status_err", {24'd0, d}, 32'h02);
        epp(1, 1'b0, 8'h00, d, r, f);
        chk("status_cleared", {24'd0, d}, 32'h00);
        epp(0, 1'b1, 8'h04, d, r, f);
        epp(1, 1'b0, 8'h00, d, r, f);
        chk("rdata_kept_after_err", {24'd0, d}, 32'hCA);
        use_err = 1'b0;
        bus.i_int = 1'b1;
        epp(0, 1'b1, 8'h08, d, r, f);
        epp(1, 1'b0, 8'h00, d, r, f);
        chk("status_int", {24'd0, d}, 32'h01);
        bus.i_int = 1'b0;

        // Unmapped index: write ignored, read zero.
        epp(0, 1'b1, 8'h09, d, r, f);
        epp(1, 1'b1, 8'h55, d, r, f);
        epp(1, 1'b0, 8'h00, d, r, f);
        chk("idx9_read", {24'd0, d}, 32'h00);
        chk("idx9_no_launch", cyc_cnt, 32'd3);

        // Both strobes: address wins, data byte 6 untouched.
        epp(2, 1'b1, 8'h06, d, r, f);
        epp(0, 1'b0, 8'h00, d, r, f);
        chk("both_index", {24'd0, d}, 32'h06);
        chk("both_data_kept", bus.o_wb_data, 32'hDEAD_BEEF);

        // Reset while the bridge waits on a stalled write.
        stall_cfg = 1000;
        epp(0, 1'b1, 8'h07, d, r, f);
        @(negedge clk);
        bus.i_write_n = 1'b0; bus.i_depp = 8'h11; bus.i_dstb_n = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("bus_active", {31'd0, bus.o_wb_cyc}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc",  {31'd0, bus.o_wb_cyc}, 32'd0);
        chk("mid_rst_stb",  {31'd0, bus.o_wb_stb}, 32'd0);
        chk("mid_rst_wait", {31'd0, bus.o_wait}, 32'd0);
        @(negedge clk);
        bus.i_dstb_n = 1'b1;
        repeat (2) @(negedge clk);
        stall_cfg = 0;
        rst_n = 1'b1;
        epp(0, 1'b1, 8'h00, d, r, f);
        epp(1, 1'b0, 8'h00, d, r, f);
        chk("post_rst_addr0", {24'd0, d}, 32'h00);
        epp(0, 1'b1, 8'h04, d, r, f);
        epp(1, 1'b0, 8'h00, d, r, f);
        chk("post_rst_rdata0", {24'd0, d}, 32'h00);
        chk("post_rst_addr", bus.o_wb_addr, 32'd0);
        chk("post_rst_data", bus.o_wb_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
